output_unit_fsm: RTL and testbench

OUTPUT_UNIT_FSM -- requirements
Module: output_unit_fsm

---
 rtl/output_unit_fsm_if.sv | 40 ++++
 rtl/output_unit_fsm.sv | 165 ++++++++++++++++
 tb/tb_output_unit_fsm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/output_unit_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : output_unit_fsm_if
// Description : Bundles the request/flit/credit handshake between the input
//               units, the downstream link and one router output unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_unit_fsm_if #(
  parameter int NUM_PORTS = 5,
  parameter int CREDITS   = 4,
  parameter int SW        = $clog2(NUM_PORTS),
  parameter int CW        = $clog2(CREDITS + 1)
);
  logic [NUM_PORTS-1:0] i_switch_req;
  logic                 i_flit_valid;
  logic                 i_flit_tail;
  logic                 i_credit_return;
  logic [NUM_PORTS-1:0] o_switch_ack;
  logic [SW-1:0]        o_sel;
  logic [1:0]           o_outstate;
  logic                 o_ready;
  logic                 o_flit_valid;
  logic [CW-1:0]        o_credit_cnt;
  logic                 o_err;

  // Requesting side: input units and downstream credit source.
  modport master (
    output i_switch_req, i_flit_valid, i_flit_tail, i_credit_return,
    input  o_switch_ack, o_sel, o_outstate, o_ready, o_flit_valid,
           o_credit_cnt, o_err
  );

  // Output unit side.
  modport slave (
    input  i_switch_req, i_flit_valid, i_flit_tail, i_credit_return,
    output o_switch_ack, o_sel, o_outstate, o_ready, o_flit_valid,
           o_credit_cnt, o_err
  );
endinterface
`default_nettype wire

// File: rtl/output_unit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : output_unit_fsm
// Description : Router output unit. Round-robin grants the output to one
//               input unit, holds ownership until the tail flit and tracks
//               downstream buffer credits.
//               Optional macro OUTPUT_UNIT_ERR_CHECK_EN enables the sticky
//               protocol-error flag o_err (tied low otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module output_unit_fsm #(
  parameter int NUM_PORTS = 5,
  parameter int CREDITS   = 4,
  parameter int SW        = $clog2(NUM_PORTS)
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  output_unit_fsm_if.slave bus
);
  localparam int            CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [SW:0]   NP       = (SW + 1)'(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTING = 2'd1,
    ACTIVE  = 2'd2,
    WAITING = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        credit;
  logic [CW-1:0]        credit_nx;
  logic [SW-1:0]        rr_ptr;
  logic [SW-1:0]        rr_ptr_nx;
  logic [SW-1:0]        sel;
  logic [SW-1:0]        winner;
  logic [NUM_PORTS-1:0] ack;
  logic                 grant;
  logic                 found;
  logic                 started;
  logic                 ready;
  logic                 flit_fwd;
  logic                 any_req;
  logic [SW:0]          cand;
  logic [SW:0]          ptr_inc;

  assign any_req  = |bus.i_switch_req;
  assign ready    = (state == ACTIVE) && (credit != '0);
  assign flit_fwd = bus.i_flit_valid && ready;

  // Marks the first edge after reset release so grants start one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) started <= 1'b0;
    else          started <= 1'b1;
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_ptr} + (SW + 1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (!found && bus.i_switch_req[cand[SW-1:0]]) begin
        found  = 1'b1;
        winner = cand[SW-1:0];
      end
    end
  end

  // Pointer moves to the input just after the owner once its tail leaves.
  always_comb begin
    ptr_inc = {1'b0, sel} + (SW + 1)'(1);
    if (ptr_inc >= NP) ptr_inc = ptr_inc - NP;
    rr_ptr_nx = rr_ptr;
    if (flit_fwd && bus.i_flit_tail) rr_ptr_nx = ptr_inc[SW-1:0];
  end

  // Next-state logic and grant decision.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (started && any_req) begin
          if (credit != '0) begin
            state_nx = ACTIVE;
            grant    = found;
          end else begin
            state_nx = WAITING;
          end
        end
      end
      WAITING: begin
        if (!any_req) begin
          state_nx = IDLE;
        end else if ((credit != '0) || bus.i_credit_return) begin
          state_nx = ACTIVE;
          grant    = found;
        end
      end
      ACTIVE: begin
        if (flit_fwd && bus.i_flit_tail) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Credit counter: returns add, forwarded flits subtract, saturates at max.
  always_comb begin
    credit_nx = credit;
    if (bus.i_credit_return && !flit_fwd) begin
      if (credit != CRED_MAX) credit_nx = credit + CW'(1);
    end else if (!bus.i_credit_return && flit_fwd) begin
      credit_nx = credit - CW'(1);
    end
  end

  // State, credit, pointer, select and grant-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      credit <= CRED_MAX;
      rr_ptr <= '0;
      sel    <= '0;
      ack    <= '0;
    end else begin
      state  <= state_nx;
      credit <= credit_nx;
      rr_ptr <= rr_ptr_nx;
      if (grant) sel <= winner;
      ack <= grant ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << winner) : '0;
    end
  end

`ifdef OUTPUT_UNIT_ERR_CHECK_EN
  logic err;
  logic overflow;
  logic stray_flit;

  assign overflow   = bus.i_credit_return && !flit_fwd && (credit == CRED_MAX);
  assign stray_flit = bus.i_flit_valid && (state != ACTIVE);

  // Sticky error: credit overflow or a flit presented without ownership.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= err | overflow | stray_flit;
  end

  assign bus.o_err = err;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_switch_ack = ack;
  assign bus.o_sel        = sel;
  assign bus.o_outstate   = state;
  assign bus.o_ready      = ready;
  assign bus.o_flit_valid = flit_fwd;
  assign bus.o_credit_cnt = credit;
endmodule
`default_nettype wire

// File: tb/tb_output_unit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_unit_fsm
// Description : Directed self-checking bench for output_unit_fsm; expected
//               grant winners are queued when requests are driven and checked
//               when the acknowledge pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_unit_fsm;
  localparam int NP = 5;
  localparam int CR = 4;
`ifdef OUTPUT_UNIT_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_q[$];

  output_unit_fsm_if #(.NUM_PORTS(NP), .CREDITS(CR)) bus ();

  output_unit_fsm #(.NUM_PORTS(NP), .CREDITS(CR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=stalled expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag);
    bit seen;
    int w;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.o_switch_ack != '0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_assert++;
    assert (seen && exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_timeout observed=no_ack expected=ack", tag);
    end
    if (seen && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk({tag, "_ack"},   32'(bus.o_switch_ack), 32'(1 << w));
      chk({tag, "_sel"},   32'(bus.o_sel),        32'(w));
      chk({tag, "_state"}, 32'(bus.o_outstate),   32'd2);
    end
  endtask

  task automatic do_reset();
    reset_n             = 1'b0;
    bus.i_switch_req    = '0;
    bus.i_flit_valid    = 1'b0;
    bus.i_flit_tail     = 1'b0;
    bus.i_credit_return = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.i_switch_req    = '0;
    bus.i_flit_valid    = 1'b0;
    bus.i_flit_tail     = 1'b0;
    bus.i_credit_return = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_state",  32'(bus.o_outstate),   32'd0);
    chk("rst_credit", 32'(bus.o_credit_cnt), 32'd4);
    chk("rst_ack",    32'(bus.o_switch_ack), 32'd0);
    chk("rst_sel",    32'(bus.o_sel),        32'd0);
    chk("rst_err",    32'(bus.o_err),        32'd0);

    // Single request at release: grant on the second edge
    reset_n          = 1'b1;
    bus.i_switch_req = 5'b00100;
    exp_q.push_back(2);
    tick();
    chk("first_edge_idle", 32'(bus.o_outstate), 32'd0);
    tick();
    wait_grant("g2");
    chk("g2_ready", 32'(bus.o_ready), 32'd1);
    bus.i_switch_req = '0;
    tick();
    chk("g2_ack_pulse", 32'(bus.o_switch_ack), 32'd0);
    bus.i_flit_valid = 1'b1;
    bus.i_flit_tail  = 1'b1;
    #1;
    chk("single_fwd", 32'(bus.o_flit_valid), 32'd1);
    tick();
    bus.i_flit_valid = 1'b0;
    bus.i_flit_tail  = 1'b0;
    chk("single_idle",   32'(bus.o_outstate),   32'd0);
    chk("single_credit", 32'(bus.o_credit_cnt), 32'd3);
    bus.i_credit_return = 1'b1;
    tick();
    bus.i_credit_return = 1'b0;
    chk("return_credit", 32'(bus.o_credit_cnt), 32'd4);

    // Round-robin: 1 then 4
    do_reset();
    bus.i_switch_req = 5'b10010;
    exp_q.push_back(1);
    tick();
    wait_grant("g1");
    bus.i_switch_req = 5'b10000;
    bus.i_flit_valid = 1'b1;
    tick();
    tick();
    bus.i_flit_tail = 1'b1;
    tick();
    bus.i_flit_valid = 1'b0;
    bus.i_flit_tail  = 1'b0;
    chk("pkt3_idle",   32'(bus.o_outstate),   32'd0);
    chk("pkt3_credit", 32'(bus.o_credit_cnt), 32'd1);
    exp_q.push_back(4);
    wait_grant("g4");
    bus.i_switch_req = '0;

    // Send with return together, then overflow at max
    bus.i_credit_return = 1'b1;
    tick();
    bus.i_flit_valid = 1'b1;
    tick();
    bus.i_flit_valid = 1'b0;
    chk("send_ret_credit", 32'(bus.o_credit_cnt), 32'd2);
    repeat (3) tick();
    bus.i_credit_return = 1'b0;
    chk("sat_credit", 32'(bus.o_credit_cnt), 32'd4);
    chk("ovf_err",    32'(bus.o_err),        32'(EXP_ERR));

    // Six-flit packet against four credits
    bus.i_flit_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("burst_fwd", 32'(bus.o_flit_valid), 32'd1);
      tick();
    end
    #1;
    chk("empty_credit", 32'(bus.o_credit_cnt), 32'd0);
    chk("empty_ready",  32'(bus.o_ready),      32'd0);
    chk("empty_nofwd",  32'(bus.o_flit_valid), 32'd0);
    tick();
    chk("stall_credit", 32'(bus.o_credit_cnt), 32'd0);
    chk("stall_state",  32'(bus.o_outstate),   32'd2);
    bus.i_credit_return = 1'b1;
    tick();
    bus.i_credit_return = 1'b0;
    #1;
    chk("fifth_fwd", 32'(bus.o_flit_valid), 32'd1);
    tick();
    bus.i_credit_return = 1'b1;
    tick();
    bus.i_credit_return = 1'b0;
    bus.i_flit_tail     = 1'b1;
    #1;
    chk("sixth_fwd", 32'(bus.o_flit_valid), 32'd1);
    tick();
    bus.i_flit_valid = 1'b0;
    bus.i_flit_tail  = 1'b0;
    chk("pkt6_idle",   32'(bus.o_outstate),   32'd0);
    chk("pkt6_credit", 32'(bus.o_credit_cnt), 32'd0);

    // Request with no credit waits, then a return grants
    bus.i_switch_req = 5'b00001;
    tick();
    chk("wait_state", 32'(bus.o_outstate), 32'd3);
    chk("wait_ready", 32'(bus.o_ready),    32'd0);
    bus.i_credit_return = 1'b1;
    exp_q.push_back(0);
    tick();
    bus.i_credit_return = 1'b0;
    wait_grant("g0");
    bus.i_switch_req = '0;
    chk("g0_credit", 32'(bus.o_credit_cnt), 32'd1);

    // Reset mid-packet at credit 1
    bus.i_flit_valid = 1'b1;
    reset_n          = 1'b0;
    #1;
    chk("mid_rst_state",  32'(bus.o_outstate),   32'd0);
    chk("mid_rst_credit", 32'(bus.o_credit_cnt), 32'd4);
    chk("mid_rst_fwd",    32'(bus.o_flit_valid), 32'd0);
    tick();
    chk("mid_rst_ack",  32'(bus.o_switch_ack), 32'd0);
    chk("mid_rst_fwd2", 32'(bus.o_flit_valid), 32'd0);
    bus.i_flit_valid = 1'b0;
    reset_n          = 1'b1;
    tick();
    tick();
    chk("post_rst_state", 32'(bus.o_outstate),   32'd0);
    chk("post_rst_ack",   32'(bus.o_switch_ack), 32'd0);
    chk("post_rst_fwd",   32'(bus.o_flit_valid), 32'd0);
    chk("post_rst_err",   32'(bus.o_err),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
